// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath/memory types used by the memory responder.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: responder state encoding and default hang-watchdog limit.
package mem_resp_pkg;
  typedef enum logic [2:0] {IDLE, IREQ, DREQ, RESP, HALT, ERR} mem_resp_state_t;
  localparam int TIMEOUT_DEFAULT = 64;
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: datapath request/response and RAM-side signals of the responder.
interface mem_responder_if
  import cpu_types_pkg::*;
;
  logic imemREN, ihit, dmemREN, dmemWEN, dhit, halt;
  logic ramREN, ramWEN, mem_err, halted;
  word_t imemaddr, imemload, dmemaddr, dmemstore, dmemload;
  word_t ramaddr, ramstore, ramload;
  ramstate_t ramstate;
  modport slave (
    input imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt, ramload, ramstate,
    output ihit, imemload, dhit, dmemload, ramREN, ramWEN, ramaddr, ramstore, mem_err, halted
  );
  modport master (
    output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt, ramload, ramstate,
    input ihit, imemload, dhit, dmemload, ramREN, ramWEN, ramaddr, ramstore, mem_err, halted
  );
endinterface

// File: rtl/mem_resp_watchdog.sv
// mem_resp_watchdog: saturating wait counter; expired flags the last permitted request cycle.
module mem_resp_watchdog
  import mem_resp_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (en_i && cnt_q != CW'(TIMEOUT)) ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  // cnt_q counts completed request cycles, so TIMEOUT-1 marks the TIMEOUT-th one
  assign expired_o = en_i && cnt_q >= CW'(TIMEOUT - 1);
endmodule

// File: rtl/mem_responder.sv
// mem_responder: arbitrates I/D requests onto a single-ported RAM with data priority.
// Define MEM_RESP_STATS_EN to add the icount/dcount/wait_count statistics ports.
module mem_responder
  import cpu_types_pkg::*, mem_resp_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  mem_responder_if.slave bus
`ifdef MEM_RESP_STATS_EN
  ,
  output word_t icount,
  output word_t dcount,
  output word_t wait_count
`endif
);
  mem_resp_state_t state_q, state_d;
  word_t addr_q, addr_d, store_q, store_d, load_q, load_d;
  logic wen_q, wen_d, dsrc_q, dsrc_d;
  logic in_req, dreq, accept, expired;
  always_comb begin
    in_req = state_q == IREQ || state_q == DREQ;
    dreq = bus.dmemWEN || bus.dmemREN;
    accept = state_q == IDLE && !bus.halt && (dreq || bus.imemREN);
    state_d = state_q;
    case (state_q)
      IDLE: state_d = bus.halt ? HALT : dreq ? DREQ : bus.imemREN ? IREQ : IDLE;
      IREQ, DREQ: state_d = bus.ramstate == ACCESS ? RESP
                          : (bus.ramstate == ERROR || expired) ? ERR : state_q;
      RESP: state_d = bus.halt ? HALT : IDLE;
      default: state_d = state_q;
    endcase
    addr_d = accept ? (dreq ? bus.dmemaddr : bus.imemaddr) : addr_q;
    store_d = accept ? bus.dmemstore : store_q;
    wen_d = accept ? bus.dmemWEN : wen_q;
    dsrc_d = accept ? dreq : dsrc_q;
    load_d = (in_req && bus.ramstate == ACCESS) ? bus.ramload : load_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q <= '0;
      store_q <= '0;
      load_q <= '0;
      wen_q <= 1'b0;
      dsrc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      store_q <= store_d;
      load_q <= load_d;
      wen_q <= wen_d;
      dsrc_q <= dsrc_d;
    end
  end
  mem_resp_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(CLK), .rst(RST), .clr_i(!in_req), .en_i(in_req), .expired_o(expired)
  );
  // RAM side is decoded from state and latches only, never from the live request inputs
  assign bus.ramREN = in_req && !wen_q;
  assign bus.ramWEN = in_req && wen_q;
  assign bus.ramaddr = in_req ? addr_q : '0;
  assign bus.ramstore = in_req ? store_q : '0;
  assign bus.ihit = state_q == RESP && !dsrc_q;
  assign bus.dhit = state_q == RESP && dsrc_q;
  assign bus.imemload = load_q;
  assign bus.dmemload = load_q;
  assign bus.mem_err = state_q == ERR;
  assign bus.halted = state_q == HALT;
`ifdef MEM_RESP_STATS_EN
  word_t icount_q, dcount_q, wait_q;
  always_ff @(posedge CLK) begin
    if (RST) begin
      icount_q <= '0;
      dcount_q <= '0;
      wait_q <= '0;
    end else begin
      icount_q <= icount_q + word_t'(bus.ihit);
      dcount_q <= dcount_q + word_t'(bus.dhit);
      wait_q <= wait_q + word_t'(in_req);
    end
  end
  assign icount = icount_q;
  assign dcount = dcount_q;
  assign wait_count = wait_q;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table-driven cycle vectors plus directed watchdog/reset/stats sequences.
module tb_mem_responder;
  import cpu_types_pkg::*;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  mem_responder_if bus ();
`ifdef MEM_RESP_STATS_EN
  word_t icount, dcount, wait_count;
  mem_responder #(.TIMEOUT(8)) dut (.CLK(CLK), .RST(RST), .bus(bus),
    .icount(icount), .dcount(dcount), .wait_count(wait_count));
`else
  mem_responder #(.TIMEOUT(8)) dut (.CLK(CLK), .RST(RST), .bus(bus));
`endif
  always #5 CLK = ~CLK;

  typedef struct {
    logic ir; word_t ia; logic dr, dw; word_t da, ds; logic h; word_t rl; ramstate_t rs;
    logic eih, edh, ldv; word_t eld; logic eren, ewen; word_t ea, es; logic ehalt;
  } vec_t;
  vec_t tv[21];

  function automatic vec_t mk(input logic ir, input word_t ia, input logic dr, input logic dw,
      input word_t da, input word_t ds, input logic h, input word_t rl, input ramstate_t rs,
      input logic eih, input logic edh, input logic ldv, input word_t eld, input logic eren,
      input logic ewen, input word_t ea, input word_t es, input logic ehalt);
    vec_t v;
    v = '{ir, ia, dr, dw, da, ds, h, rl, rs, eih, edh, ldv, eld, eren, ewen, ea, es, ehalt};
    return v;
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input word_t act, input word_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic outs(input string p, input logic ih, input logic dh, input logic ren,
      input logic wen, input word_t a, input word_t s, input logic err, input logic hlt);
    chk({p, " ihit"}, 32'(bus.ihit), 32'(ih));
    chk({p, " dhit"}, 32'(bus.dhit), 32'(dh));
    chk({p, " ramREN"}, 32'(bus.ramREN), 32'(ren));
    chk({p, " ramWEN"}, 32'(bus.ramWEN), 32'(wen));
    chk({p, " ramaddr"}, bus.ramaddr, a);
    chk({p, " ramstore"}, bus.ramstore, s);
    chk({p, " mem_err"}, 32'(bus.mem_err), 32'(err));
    chk({p, " halted"}, 32'(bus.halted), 32'(hlt));
  endtask

  task automatic idle_in;
    bus.imemREN = 0; bus.imemaddr = 0; bus.dmemREN = 0; bus.dmemWEN = 0;
    bus.dmemaddr = 0; bus.dmemstore = 0; bus.halt = 0; bus.ramload = 0; bus.ramstate = FREE;
  endtask

  task automatic do_reset;
    RST = 1;
    tick;
    RST = 0;
  endtask

  task automatic dreq_start(input word_t a);
    bus.dmemREN = 1; bus.dmemaddr = a; bus.ramstate = BUSY;
    tick;
    bus.dmemREN = 0; bus.dmemaddr = 0;
  endtask

`ifdef MEM_RESP_STATS_EN
  task automatic xfer(input logic d, input word_t a, input word_t data);
    bus.imemREN = !d; bus.imemaddr = a; bus.dmemREN = d; bus.dmemaddr = a;
    tick;
    bus.imemREN = 0; bus.dmemREN = 0; bus.ramstate = BUSY;
    tick;
    bus.ramstate = ACCESS; bus.ramload = data;
    tick;
    chk($sformatf("xfer %h hit", a), 32'(d ? bus.dhit : bus.ihit), 32'd1);
    chk($sformatf("xfer %h load", a), d ? bus.dmemload : bus.imemload, data);
    bus.ramstate = FREE;
    tick;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tv[0]  = mk(1,'h40,0,0,0,0,0,0,FREE,                  0,0,0,0,0,0,0,0,0);
    tv[1]  = mk(1,'h40,0,0,0,0,0,0,BUSY,                  0,0,0,0,1,0,'h40,0,0);
    tv[2]  = mk(1,'h40,0,0,0,0,0,0,BUSY,                  0,0,0,0,1,0,'h40,0,0);
    tv[3]  = mk(0,'h40,0,0,0,0,0,'h8C220004,ACCESS,       0,0,0,0,1,0,'h40,0,0);
    tv[4]  = mk(0,0,0,0,0,0,0,0,FREE,                     1,0,1,'h8C220004,0,0,0,0,0);
    tv[5]  = mk(1,'h44,1,0,'h100,0,0,'h12345678,ACCESS,   0,0,0,0,0,0,0,0,0);
    tv[6]  = mk(1,'h44,0,0,'h999,0,0,'h12345678,ACCESS,   0,0,0,0,1,0,'h100,0,0);
    tv[7]  = mk(1,'h44,0,0,0,0,0,'hABCD,ACCESS,           0,1,1,'h12345678,0,0,0,0,0);
    tv[8]  = mk(1,'h44,0,0,0,0,0,'hABCD,ACCESS,           0,0,0,0,0,0,0,0,0);
    tv[9]  = mk(0,'h44,0,0,0,0,0,'hABCD,ACCESS,           0,0,0,0,1,0,'h44,0,0);
    tv[10] = mk(0,0,1,1,'h200,'hDEADBEEF,0,0,BUSY,        1,0,1,'hABCD,0,0,0,0,0);
    tv[11] = mk(0,0,1,1,'h200,'hDEADBEEF,0,0,BUSY,        0,0,0,0,0,0,0,0,0);
    tv[12] = mk(0,0,0,0,'h200,0,0,0,BUSY,                 0,0,0,0,0,1,'h200,'hDEADBEEF,0);
    tv[13] = mk(0,0,0,0,0,0,0,'h11111111,ACCESS,          0,0,0,0,0,1,'h200,'hDEADBEEF,0);
    tv[14] = mk(0,0,0,0,0,0,0,0,FREE,                     0,1,0,0,0,0,0,0,0);
    tv[15] = mk(0,0,1,0,'h300,0,0,0,BUSY,                 0,0,0,0,0,0,0,0,0);
    tv[16] = mk(0,0,0,0,0,0,1,'hCAFEF00D,ACCESS,          0,0,0,0,1,0,'h300,0,0);
    tv[17] = mk(1,'h50,0,0,0,0,1,0,FREE,                  0,1,1,'hCAFEF00D,0,0,0,0,0);
    tv[18] = mk(1,'h50,1,0,0,0,1,0,ACCESS,                0,0,0,0,0,0,0,0,1);
    tv[19] = mk(0,0,0,0,0,0,0,0,FREE,                     0,0,0,0,0,0,0,0,1);
    tv[20] = mk(0,0,0,0,0,0,0,0,FREE,                     0,0,0,0,0,0,0,0,1);

    idle_in;
    bus.imemREN = 1; bus.dmemWEN = 1; bus.ramstate = ACCESS; bus.ramload = 'h55;
    tick;
    tick;
    RST = 0;
    idle_in;
    outs("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset imemload", bus.imemload, 0);
    chk("reset dmemload", bus.dmemload, 0);

    for (int i = 0; i < 21; i++) begin
      outs($sformatf("r%0d", i), tv[i].eih, tv[i].edh, tv[i].eren, tv[i].ewen,
           tv[i].ea, tv[i].es, 0, tv[i].ehalt);
      if (tv[i].ldv)
        chk($sformatf("r%0d load", i), tv[i].eih ? bus.imemload : bus.dmemload, tv[i].eld);
      bus.imemREN = tv[i].ir; bus.imemaddr = tv[i].ia; bus.dmemREN = tv[i].dr;
      bus.dmemWEN = tv[i].dw; bus.dmemaddr = tv[i].da; bus.dmemstore = tv[i].ds;
      bus.halt = tv[i].h; bus.ramload = tv[i].rl; bus.ramstate = tv[i].rs;
      tick;
    end

    idle_in;
    do_reset;
    outs("halt-reset", 0, 0, 0, 0, 0, 0, 0, 0);
    dreq_start('h400);
    for (int k = 1; k <= 8; k++) begin
      outs($sformatf("wd c%0d", k), 0, 0, 1, 0, 'h400, 0, 0, 0);
      tick;
    end
    bus.ramstate = ACCESS; bus.dmemREN = 1; bus.imemREN = 1;
    for (int k = 0; k < 3; k++) begin
      outs($sformatf("wd err%0d", k), 0, 0, 0, 0, 0, 0, 1, 0);
      tick;
    end
    idle_in;
    do_reset;
    outs("wd cleared", 0, 0, 0, 0, 0, 0, 0, 0);

    dreq_start('h404);
    for (int k = 1; k < 8; k++) tick;
    bus.ramstate = ACCESS; bus.ramload = 'h0BADF00D;
    tick;
    bus.ramstate = FREE;
    outs("access-wins", 0, 1, 0, 0, 0, 0, 0, 0);
    chk("access-wins load", bus.dmemload, 'h0BADF00D);
    tick;

    dreq_start('h408);
    bus.ramstate = ERROR;
    tick;
    bus.ramstate = FREE;
    outs("ram-error", 0, 0, 0, 0, 0, 0, 1, 0);
    do_reset;

    bus.imemREN = 1; bus.imemaddr = 'h60; bus.ramstate = BUSY;
    tick;
    outs("rst-mid ireq", 0, 0, 1, 0, 'h60, 0, 0, 0);
    RST = 1; bus.ramstate = ACCESS; bus.ramload = 'h77;
    tick;
    RST = 0; bus.imemREN = 0;
    outs("rst-mid after", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst-mid imemload", bus.imemload, 0);
    tick;
    outs("rst-mid nohit", 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef MEM_RESP_STATS_EN
    idle_in;
    do_reset;
    chk("stats icount reset", icount, 0);
    chk("stats wait reset", wait_count, 0);
    xfer(0, 'h10, 'hA1);
    xfer(1, 'h20, 'hB2);
    xfer(0, 'h14, 'hA3);
    xfer(1, 'h24, 'hB4);
    xfer(0, 'h18, 'hA5);
    chk("stats icount", icount, 3);
    chk("stats dcount", dcount, 2);
    chk("stats wait_count", wait_count, 10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
